// File: rtl/enemy_spawn_scheduler.sv
// Enemy spawn scheduler: offers every slot that was dead at stage entry, one per
// SPAWN_INTERVAL, over a valid/ack handshake. Optional macro RAND_POS_EN randomises spawn_x.
module enemy_spawn_scheduler #(
    parameter int FLY_COUNT      = 4,
    parameter int MOSQUITO_COUNT = 12,
    parameter int SPAWN_INTERVAL = 2_500_000,
    parameter int X_MIN          = 32,
    parameter int X_STEP         = 32,
    localparam int N             = FLY_COUNT + MOSQUITO_COUNT,
    localparam int SW            = $clog2(N)
) (
    input  logic          clk25,
    input  logic          rst_n,
    input  logic [1:0]    stage_state,
    input  logic [N-1:0]  enemy_alive,
    input  logic          spawn_ack,
    output logic          spawn_valid,
    output logic [SW-1:0] spawn_slot,
    output logic [9:0]    spawn_x,
    output logic          wave_done
);

    localparam int CW = $clog2(SPAWN_INTERVAL) + 1;
    localparam logic [1:0] STAGE_NORMAL = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_OFFER,
        S_DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [1:0]      prev_stage;
    logic [N-1:0]    pending;
    logic [N-1:0]    pending_cleared;
    logic [CW-1:0]   counter;
    logic [SW-1:0]   first_slot;
    logic [9:0]      x_calc;
    logic            entry;
    logic            abort;
    logic            interval_hit;

    assign entry        = (stage_state == STAGE_NORMAL) && (prev_stage != STAGE_NORMAL);
    assign abort        = (state_q != S_IDLE) && (stage_state != STAGE_NORMAL);
    assign interval_hit = (counter == CW'(SPAWN_INTERVAL - 1));
    assign pending_cleared = pending & ~(N'(1) << spawn_slot);

    // Lowest-index pending slot wins.
    always_comb begin
        first_slot = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (pending[i-1]) first_slot = SW'(i - 1);
        end
    end

`ifdef RAND_POS_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk25) begin
        if (!rst_n) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    always_comb x_calc = 10'(X_MIN + int'({1'b0, lfsr[8:0]}));
`else
    always_comb x_calc = 10'(X_MIN + int'(first_slot) * X_STEP);
`endif

    always_ff @(posedge clk25) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (entry) state_d = (~enemy_alive == '0) ? S_DONE : S_WAIT;
            S_WAIT:  if (interval_hit) state_d = S_OFFER;
            S_OFFER: if (spawn_ack) state_d = (pending_cleared == '0) ? S_DONE : S_WAIT;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    // prev_stage keeps tracking through reset so a reset inside stage 01 does not re-arm the wave.
    always_ff @(posedge clk25) begin
        prev_stage <= stage_state;
        if (!rst_n) begin
            pending     <= '0;
            counter     <= '0;
            spawn_valid <= 1'b0;
            spawn_slot  <= '0;
            spawn_x     <= '0;
            wave_done   <= 1'b0;
        end else if (abort) begin
            pending     <= '0;
            spawn_valid <= 1'b0;
            wave_done   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    spawn_valid <= 1'b0;
                    spawn_slot  <= '0;
                    spawn_x     <= '0;
                    wave_done   <= 1'b0;
                    if (entry) begin
                        pending <= ~enemy_alive;
                        counter <= '0;
                    end
                end
                S_WAIT: begin
                    counter <= counter + 1'b1;
                    if (interval_hit) begin
                        spawn_valid <= 1'b1;
                        spawn_slot  <= first_slot;
                        spawn_x     <= x_calc;
                    end
                end
                S_OFFER: begin
                    if (spawn_ack) begin
                        pending     <= pending_cleared;
                        spawn_valid <= 1'b0;
                        counter     <= '0;
                    end
                end
                S_DONE: wave_done <= 1'b1;
                default: spawn_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Directed bench for enemy_spawn_scheduler: 2 flies, 2 mosquitoes, 4-tick interval.
module tb_enemy_spawn_scheduler;

    localparam int SW = 2;

    logic          clk25 = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    stage_state = 2'b00;
    logic [3:0]    enemy_alive = 4'b0000;
    logic          spawn_ack = 1'b0;
    logic          spawn_valid;
    logic [SW-1:0] spawn_slot;
    logic [9:0]    spawn_x;
    logic          wave_done;

    int compared = 0;
    int mismatched = 0;

    always #5 clk25 = ~clk25;

    enemy_spawn_scheduler #(
        .FLY_COUNT(2),
        .MOSQUITO_COUNT(2),
        .SPAWN_INTERVAL(4),
        .X_MIN(32),
        .X_STEP(32)
    ) dut (
        .clk25(clk25),
        .rst_n(rst_n),
        .stage_state(stage_state),
        .enemy_alive(enemy_alive),
        .spawn_ack(spawn_ack),
        .spawn_valid(spawn_valid),
        .spawn_slot(spawn_slot),
        .spawn_x(spawn_x),
        .wave_done(wave_done)
    );

    task automatic tick;
        @(negedge clk25);
    endtask

    // Ticks until spawn_valid is seen, bounded at 20 cycles.
    task automatic wait_valid(output int k);
        k = 0;
        do begin
            tick();
            k++;
        end while (spawn_valid !== 1'b1 && k < 20);
    endtask

    task automatic pulse_ack;
        spawn_ack = 1'b1;
        tick();
        spawn_ack = 1'b0;
    endtask

    task automatic go_idle;
        spawn_ack = 1'b0;
        stage_state = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        compared++;
        if ({spawn_valid, spawn_slot, spawn_x, wave_done} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got v=%b s=%0d x=%0d d=%b, need all 0",
                     spawn_valid, spawn_slot, spawn_x, wave_done);
        end
        rst_n = 1'b1;
        tick();
        compared++;
        if (spawn_valid !== 1'b0 || wave_done !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_release: got v=%b d=%b, need 0 0", spawn_valid, wave_done);
        end
    endtask

    task automatic test_full_wave;
        int k;
        int exp_x[4] = '{32, 64, 96, 128};
        go_idle();
        enemy_alive = 4'b0000;
        stage_state = 2'b01;
        for (int s = 0; s < 4; s++) begin
            wait_valid(k);
            compared++;
            if (k !== (s == 0 ? 5 : 4)) begin
                mismatched++;
                $display("FAIL full_latency%0d: got %0d cycles, need %0d", s, k, (s == 0 ? 5 : 4));
            end
            compared++;
            if (spawn_slot !== SW'(s)) begin
                mismatched++;
                $display("FAIL full_slot%0d: got %0d, need %0d", s, spawn_slot, s);
            end
            compared++;
            if (spawn_x !== 10'(exp_x[s])) begin
                mismatched++;
                $display("FAIL full_x%0d: got %0d, need %0d", s, spawn_x, exp_x[s]);
            end
            pulse_ack();
            compared++;
            if (spawn_valid !== 1'b0 || wave_done !== 1'b0) begin
                mismatched++;
                $display("FAIL full_after_ack%0d: got v=%b d=%b, need 0 0", s, spawn_valid, wave_done);
            end
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            compared++;
            if (wave_done !== 1'b1 || spawn_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL full_done%0d: got d=%b v=%b, need 1 0", c, wave_done, spawn_valid);
            end
        end
    endtask

    task automatic test_partial_wave;
        int k;
        int exp_slot[2] = '{1, 3};
        int exp_x[2] = '{64, 128};
        go_idle();
        enemy_alive = 4'b0101;
        stage_state = 2'b01;
        tick();
        // Membership was fixed at entry; later alive changes must not drop offers.
        enemy_alive = 4'b1111;
        for (int s = 0; s < 2; s++) begin
            wait_valid(k);
            compared++;
            if (k !== 4) begin
                mismatched++;
                $display("FAIL partial_latency%0d: got %0d cycles, need 4", s, k);
            end
            compared++;
            if (spawn_slot !== SW'(exp_slot[s]) || spawn_x !== 10'(exp_x[s])) begin
                mismatched++;
                $display("FAIL partial_offer%0d: got slot %0d x %0d, need slot %0d x %0d",
                         s, spawn_slot, spawn_x, exp_slot[s], exp_x[s]);
            end
            pulse_ack();
        end
        tick();
        compared++;
        if (wave_done !== 1'b1) begin
            mismatched++;
            $display("FAIL partial_done: got %b, need 1", wave_done);
        end
    endtask

    task automatic test_all_alive;
        logic saw_valid;
        go_idle();
        enemy_alive = 4'b1111;
        stage_state = 2'b01;
        tick();
        compared++;
        if (wave_done !== 1'b0) begin
            mismatched++;
            $display("FAIL alive_done_early: got %b, need 0", wave_done);
        end
        tick();
        compared++;
        if (wave_done !== 1'b1) begin
            mismatched++;
            $display("FAIL alive_done: got %b, need 1", wave_done);
        end
        saw_valid = spawn_valid;
        for (int c = 0; c < 10; c++) begin
            tick();
            saw_valid = saw_valid | spawn_valid;
        end
        compared++;
        if (saw_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL alive_no_offer: got valid %b, need 0", saw_valid);
        end
    endtask

    task automatic test_abort;
        int k;
        go_idle();
        enemy_alive = 4'b0000;
        stage_state = 2'b01;
        wait_valid(k);
        pulse_ack();
        wait_valid(k);
        compared++;
        if (spawn_slot !== SW'(1)) begin
            mismatched++;
            $display("FAIL abort_pre_slot: got %0d, need 1", spawn_slot);
        end
        spawn_ack = 1'b1;
        stage_state = 2'b10;
        tick();
        spawn_ack = 1'b0;
        compared++;
        if (spawn_valid !== 1'b0 || wave_done !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_clear: got v=%b d=%b, need 0 0", spawn_valid, wave_done);
        end
        tick();
        stage_state = 2'b01;
        wait_valid(k);
        compared++;
        if (k !== 5 || spawn_slot !== SW'(0) || spawn_x !== 10'd32) begin
            mismatched++;
            $display("FAIL abort_reentry: got %0d cycles slot %0d x %0d, need 5 cycles slot 0 x 32",
                     k, spawn_slot, spawn_x);
        end
        pulse_ack();
    endtask

    task automatic test_stall;
        int k;
        go_idle();
        enemy_alive = 4'b0000;
        stage_state = 2'b01;
        wait_valid(k);
        for (int c = 0; c < 20; c++) begin
            tick();
            compared++;
            if (spawn_valid !== 1'b1 || spawn_slot !== SW'(0) || spawn_x !== 10'd32) begin
                mismatched++;
                $display("FAIL stall%0d: got v=%b slot %0d x %0d, need v=1 slot 0 x 32",
                         c, spawn_valid, spawn_slot, spawn_x);
            end
        end
        pulse_ack();
        compared++;
        if (spawn_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL stall_release: got v=%b, need 0", spawn_valid);
        end
    endtask

    task automatic test_reset_mid_offer;
        int k;
        logic saw_valid;
        go_idle();
        enemy_alive = 4'b0000;
        stage_state = 2'b01;
        wait_valid(k);
        compared++;
        if (spawn_valid !== 1'b1 || spawn_x !== 10'd32) begin
            mismatched++;
            $display("FAIL midrst_pre: got v=%b x %0d, need v=1 x 32", spawn_valid, spawn_x);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        compared++;
        if ({spawn_valid, spawn_slot, spawn_x, wave_done} !== '0) begin
            mismatched++;
            $display("FAIL midrst_outputs: got v=%b s=%0d x=%0d d=%b, need all 0",
                     spawn_valid, spawn_slot, spawn_x, wave_done);
        end
        saw_valid = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            saw_valid = saw_valid | spawn_valid;
        end
        compared++;
        if (saw_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL midrst_no_rearm: got valid %b, need 0", saw_valid);
        end
    endtask

    initial begin
        test_reset();
        test_full_wave();
        test_partial_wave();
        test_all_alive();
        test_abort();
        test_stall();
        test_reset_mid_offer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
